// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int          INSN_W   = 32;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    RUN,
    FAULT
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INSN_W-1:0] insn;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// In-order instruction buffer holding fetched words with their PCs.
// Exposes the head and the entry behind it so the owner can register the next head.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ifu_entry_t               push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output ifu_entry_t               head,
  output ifu_entry_t               head_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifu_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Clear wins over a simultaneous push: the word belongs to the abandoned path.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with in-order buffering and redirect flush.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          misaligned;
  logic          nxt_valid;
  ifu_entry_t    head;
  ifu_entry_t    head_next;
  ifu_entry_t    push_entry;
  ifu_entry_t    nxt_entry;

`ifdef IFU_MISALIGN_CHECK_EN
  assign target_pc  = redirect_pc;
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  // Live occupancy counts buffered words plus requests whose words will be kept.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop_cnt};
  assign imem_req_valid = !rst && (state == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH))
                          && (outstanding < CW'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_cnt == '0) && !redirect && (state == RUN);
  assign pop            = ins_valid && ins_ready;
  assign push_entry     = '{pc: rsp_pc, insn: imem_rsp_data};

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head),
    .head_next (head_next)
  );

  // The output registers track what the buffer head will be after this edge.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_entry = head;
    if (!redirect && state == RUN) begin
      if (pop) begin
        if (fifo_count > CW'(1)) begin
          nxt_valid = 1'b1;
          nxt_entry = head_next;
        end else if (push) begin
          nxt_valid = 1'b1;
          nxt_entry = push_entry;
        end
      end else if (!fifo_empty) begin
        nxt_valid = 1'b1;
        nxt_entry = head;
      end else if (push) begin
        nxt_valid = 1'b1;
        nxt_entry = push_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_fault <= 1'b0;
      ins_valid   <= 1'b0;
      ins         <= '0;
      ins_pc      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        drop_cnt <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        if (misaligned) begin
          state       <= FAULT;
          fetch_fault <= 1'b1;
        end
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_INC;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) rsp_pc <= rsp_pc + PC_INC;
      end
      ins_valid <= nxt_valid;
      if (nxt_valid) begin
        ins    <= nxt_entry.insn;
        ins_pc <= nxt_entry.pc;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with an in-order fixed-latency memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  int          got_cyc[$];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ins            (ins),
    .ins_pc         (ins_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is its address with a fixed pattern in the upper half.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at a negedge: drive inputs, log handshakes, advance.
  task automatic applyStimulus(input logic rq_rdy, input logic in_rdy,
                               input logic redir, input logic [31:0] rpc);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    imem_req_ready = rq_rdy;
    ins_ready      = in_rdy;
    redirect       = redir;
    redirect_pc    = rpc;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
      acc_addr.push_back(imem_req_addr);
    end
    if (ins_valid && ins_ready) begin
      got_pc.push_back(ins_pc);
      got_ins.push_back(ins);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clearLogs();
    acc_addr.delete();
    got_pc.delete();
    got_ins.delete();
    got_cyc.delete();
  endtask

  // Resets DUT and memory together, checks reset values, then releases reset.
  task automatic doReset();
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_ins_valid", 32'(ins_valid), 32'd0);
    checkOutput("rst_ins", ins, 32'h0);
    checkOutput("rst_ins_pc", ins_pc, 32'h0);
    checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
    pend_addr.delete();
    pend_due.delete();
    clearLogs();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Delivered words must be n consecutive PCs from base, each carrying its memory word.
  task automatic checkStream(input string tag, input logic [31:0] base, input int n);
    logic [31:0] exp_pc;
    checkOutput({tag, "_count"}, 32'(got_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < got_pc.size()) begin
        exp_pc = base + 32'(4 * i);
        checkOutput({tag, "_pc"}, got_pc[i], exp_pc);
        checkOutput({tag, "_ins"}, got_ins[i], memWord(exp_pc));
      end
    end
  endtask

  initial begin
    @(negedge clk);

    // Streaming at latency 1 with the decoder always ready.
    lat = 1;
    doReset();
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t1_acc_n", 32'(acc_addr.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < acc_addr.size()) checkOutput("t1_req_addr", acc_addr[i], 32'(4 * i));
    if (got_cyc.size() > 0) checkOutput("t1_first_valid", 32'(got_cyc[0] <= 3), 32'd1);
    checkStream("t1", 32'h0, 6);
    for (int i = 1; i < 6; i++)
      if (i < got_cyc.size()) checkOutput("t1_b2b", 32'(got_cyc[i] - got_cyc[0]), 32'(i));

    // Decoder stalled for 10 cycles at latency 2, then released.
    lat = 2;
    doReset();
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_issued", 32'(acc_addr.size()), 32'd4);
    checkOutput("t2_hold_valid", 32'(ins_valid), 32'd1);
    checkOutput("t2_hold_pc", ins_pc, 32'h0);
    checkOutput("t2_hold_ins", ins, 32'h5A5A_0000);
    repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkStream("t2", 32'h0, 5);

    // Three requests in flight at latency 3, redirect to 0x100.
    lat = 3;
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
    checkOutput("t3_flush_valid", 32'(ins_valid), 32'd0);
    checkOutput("t3_none_before", 32'(got_pc.size()), 32'd0);
    repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkStream("t3", 32'h100, 3);
    if (got_ins.size() > 0) checkOutput("t3_word", got_ins[0], 32'h5A5A_0100);

    // Redirect coinciding with a request handshake and a response arrival.
    lat = 2;
    doReset();
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkStream("t4", 32'h200, 3);
    if (acc_addr.size() > 3) checkOutput("t4_restart_addr", acc_addr[3], 32'h200);

    // Address wrap past the top of the address space.
    lat = 1;
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkStream("t5", 32'hFFFF_FFF8, 4);
    checkOutput("t5_acc_n", 32'(acc_addr.size() >= 4), 32'd1);
    if (acc_addr.size() > 3) begin
      checkOutput("t5_addr_top", acc_addr[2], 32'hFFFF_FFFC);
      checkOutput("t5_addr_wrap", acc_addr[3], 32'h0000_0000);
    end

    // Misaligned redirect target.
    lat = 1;
    doReset();
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
    clearLogs();
`ifdef IFU_MISALIGN_CHECK_EN
    checkOutput("t6_fault", 32'(fetch_fault), 32'd1);
    checkOutput("t6_req_off", 32'(imem_req_valid), 32'd0);
    checkOutput("t6_ins_off", 32'(ins_valid), 32'd0);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_fault_sticky", 32'(fetch_fault), 32'd1);
    checkOutput("t6_req_still_off", 32'(imem_req_valid), 32'd0);
    checkOutput("t6_ins_still_off", 32'(ins_valid), 32'd0);
    checkOutput("t6_no_delivery", 32'(got_pc.size()), 32'd0);
`else
    checkOutput("t6_no_fault", 32'(fetch_fault), 32'd0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkStream("t6", 32'h100, 2);
`endif
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end block that produces the 32-bit instruction word `ins` consumed by the general control/decode stage.
- Issues sequential word fetches to the instruction memory port.
- Buffers returned words in a small in-order FIFO with their PCs.
- Presents them downstream with a valid/ready handshake.
- On a taken branch/jump from the pipeline, flushes the buffer, discards in-flight responses and restarts at the target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2
MAX_OUTSTANDING, 4, max issued-but-unreturned imem requests; ≤ FIFO_DEPTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response word valid; responses return in order, latency ≥1, never back-pressured
imem_rsp_data  in  32  fetched instruction word
ins  out  32  instruction to decode stage
ins_pc  out  32  PC of ins
ins_valid  out  1  ins/ins_pc valid
ins_ready  in  1  decode stage consumes (stall when 0)
redirect  in  1  taken branch/jump/JALR this cycle
redirect_pc  in  32  new PC when redirect=1
fetch_fault  out  1  misaligned redirect trap (feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, ins_valid=0, ins=0, ins_pc=0, fetch_fault=0.
- Issue:
  - imem_req_valid=1 when (fifo_count + outstanding − drop_cnt) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING and state=RUN.
  - imem_req_addr=fetch_pc. On valid&&ready: fetch_pc += 4 (wraps modulo 2^32) and outstanding++.
- Response:
  - imem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the word is discarded and drop_cnt--.
  - Otherwise the word is pushed with its PC. The PC comes from a shadow counter rsp_pc that increments 4 per accepted response.
- Output:
  - ins/ins_pc/ins_valid driven registered from the FIFO head. Push→visible latency is 1 cycle.
  - A pop occurs on ins_valid&&ins_ready.
  - ins/ins_pc stay stable while ins_valid&&!ins_ready.
- Redirect (highest priority):
  - FIFO cleared and ins_valid=0 next cycle.
  - drop_cnt = outstanding + (request accepted this cycle) − (response arriving this cycle).
  - fetch_pc=rsp_pc=redirect_pc.
  - Any pop in the same cycle completes normally.
  - A request accepted in the redirect cycle is counted as stale.
- Simultaneous push and pop with FIFO full: allowed; count unchanged.
- Overflow is impossible by the issue rule. Any push while full is an assertion failure.
- States: RUN, FAULT (FAULT only with feature).
  - RUN→FAULT on a misaligned redirect.
  - FAULT→RUN only by rst.
- rst mid-operation: all in-flight responses are ignored. Memory is required to be reset concurrently.

Optional Feature:
Macro IFU_MISALIGN_CHECK_EN.
- With the macro: redirect with redirect_pc[1:0]≠0 triggers the following:
  - Enters FAULT.
  - Flushes as a normal redirect.
  - Asserts fetch_fault (sticky until rst).
  - Stops issuing.
  - Holds ins_valid=0.
- Without the macro:
  - redirect_pc[1:0] is forced to 0.
  - fetch_fault is tied 0.
  - No FAULT state.

Decomposition:
- Package ifu_pkg:
  - Constants INSN_W=32, PC_INC=4, NOP_INSN=32'h0000_0013.
  - Enum ifu_state_e {RUN, FAULT}.
  - Struct ifu_entry_t {pc[31:0], insn[31:0]}.
- Sub-module ifu_fifo: synchronous FIFO of ifu_entry_t with push/pop/clear/full/empty/count. Parameter DEPTH.

Test Plan:
- Reset, ins_ready=1, memory latency 1: imem_req_addr issues 0,4,8,…; ins_pc streams 0,4,8 back-to-back; first ins_valid ≤3 cycles after rst deasserts.
- ins_ready=0 for 10 cycles, latency 2: issue stops after 4 words total; ins/ins_pc hold at PC 0. On release, PCs 0,4,8,12,16 appear in order with no gaps or duplicates.
- Latency 3 with 3 requests outstanding, redirect_pc=32'h100: the 3 stale words are dropped. The next ins_pc=32'h100 with the word fetched from 0x100.
- Redirect in the same cycle as a request handshake and a response arrival: drop_cnt is correct. The first delivered ins_pc equals redirect_pc.
- fetch_pc=32'hFFFF_FFF8: addresses wrap to 32'hFFFF_FFFC then 32'h0000_0000.
- With IFU_MISALIGN_CHECK_EN, redirect_pc=32'h102: fetch_fault=1 next cycle, imem_req_valid=0 and ins_valid=0 until rst. Without the macro, fetch resumes at 32'h100.
